// File: rtl/mips_pkg.sv
// Shared decode constants, ALU operation encoding and the decoded-control
// struct for the single-cycle MIPS32 integer core.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic { DST_RT, DST_RD } dst_sel_e;
  typedef enum logic { EXT_SIGN, EXT_ZERO } ext_sel_e;

  typedef struct packed {
    logic     reg_write;
    dst_sel_e dst_sel;
    ext_sel_e imm_ext_sel;
    logic     alu_src_imm;
    alu_op_e  alu_op;
    logic     ovf_chk;
  } ctrl_t;

endpackage

// File: rtl/mips_regfile.sv
// 2R+1W register file with async active-low clear; entry 0 is never written
// and always reads zero.
module mips_regfile #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [AW-1:0]     raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o,
  input  logic [AW-1:0]     raddr_d_i,
  output logic [DATA_W-1:0] rdata_d_o
);

  logic [DATA_W-1:0] register_file [0:NUM_REGS-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) register_file[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      register_file[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : register_file[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : register_file[raddr_b_i];
  assign rdata_d_o = (raddr_d_i == '0) ? '0 : register_file[raddr_d_i];

endmodule

// File: rtl/mips_cpu.sv
// Single-cycle MIPS32 integer core (decode, register file, ALU, write-back).
// Define MIPS_CPU_OVF_TRAP_EN to trap signed overflow on add/sub/addi.
module mips_cpu import mips_pkg::*; #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [31:0]       instruction,
  input  logic [4:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [DATA_W-1:0] alu_result,
  output logic              overflow
);

  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd, shamt;
  logic [15:0]       imm;
  ctrl_t             ctrl;
  logic [DATA_W-1:0] rs_data, rt_data, imm_ext, op_a, op_b, sum, diff;
  logic              ovf, wb_en;

  assign opcode = instruction[31:26];
  assign rs     = instruction[25:21];
  assign rt     = instruction[20:16];
  assign rd     = instruction[15:11];
  assign shamt  = instruction[10:6];
  assign funct  = instruction[5:0];
  assign imm    = instruction[15:0];

  // Anything not explicitly decoded (including X/Z words) leaves reg_write low.
  always_comb begin
    ctrl.reg_write   = 1'b0;
    ctrl.dst_sel     = DST_RT;
    ctrl.imm_ext_sel = EXT_SIGN;
    ctrl.alu_src_imm = 1'b0;
    ctrl.alu_op      = ALU_ADD;
    ctrl.ovf_chk     = 1'b0;
    if (!$isunknown(instruction)) begin
      case (opcode)
        OP_RTYPE: begin
          ctrl.reg_write = 1'b1;
          ctrl.dst_sel   = DST_RD;
          case (funct)
            FN_ADD:  begin ctrl.alu_op = ALU_ADD; ctrl.ovf_chk = 1'b1; end
            FN_ADDU: ctrl.alu_op = ALU_ADD;
            FN_SUB:  begin ctrl.alu_op = ALU_SUB; ctrl.ovf_chk = 1'b1; end
            FN_SUBU: ctrl.alu_op = ALU_SUB;
            FN_AND:  ctrl.alu_op = ALU_AND;
            FN_OR:   ctrl.alu_op = ALU_OR;
            FN_XOR:  ctrl.alu_op = ALU_XOR;
            FN_NOR:  ctrl.alu_op = ALU_NOR;
            FN_SLT:  ctrl.alu_op = ALU_SLT;
            FN_SLTU: ctrl.alu_op = ALU_SLTU;
            FN_SLL:  ctrl.alu_op = ALU_SLL;
            FN_SRL:  ctrl.alu_op = ALU_SRL;
            FN_SRA:  ctrl.alu_op = ALU_SRA;
            default: ctrl.reg_write = 1'b0;
          endcase
        end
        OP_ADDI:  begin ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.ovf_chk = 1'b1; end
        OP_ADDIU: begin ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1; end
        OP_SLTI:  begin ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.alu_op = ALU_SLT; end
        OP_SLTIU: begin ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1; ctrl.alu_op = ALU_SLTU; end
        OP_ANDI: begin
          ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1;
          ctrl.imm_ext_sel = EXT_ZERO; ctrl.alu_op = ALU_AND;
        end
        OP_ORI: begin
          ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1;
          ctrl.imm_ext_sel = EXT_ZERO; ctrl.alu_op = ALU_OR;
        end
        OP_XORI: begin
          ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1;
          ctrl.imm_ext_sel = EXT_ZERO; ctrl.alu_op = ALU_XOR;
        end
        OP_LUI: begin
          ctrl.reg_write = 1'b1; ctrl.alu_src_imm = 1'b1;
          ctrl.imm_ext_sel = EXT_ZERO; ctrl.alu_op = ALU_LUI;
        end
        default: ;
      endcase
    end
  end

  assign imm_ext = (ctrl.imm_ext_sel == EXT_ZERO) ? {{(DATA_W-16){1'b0}}, imm}
                                                  : {{(DATA_W-16){imm[15]}}, imm};
  // Shifts operate on rt; op_b carries rt for every R-type instruction.
  assign op_a = rs_data;
  assign op_b = ctrl.alu_src_imm ? imm_ext : rt_data;
  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;

  always_comb begin
    alu_result = sum;
    case (ctrl.alu_op)
      ALU_ADD:  alu_result = sum;
      ALU_SUB:  alu_result = diff;
      ALU_AND:  alu_result = op_a & op_b;
      ALU_OR:   alu_result = op_a | op_b;
      ALU_XOR:  alu_result = op_a ^ op_b;
      ALU_NOR:  alu_result = ~(op_a | op_b);
      ALU_SLT:  alu_result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_result = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
      ALU_SLL:  alu_result = op_b << shamt;
      ALU_SRL:  alu_result = op_b >> shamt;
      ALU_SRA:  alu_result = $signed(op_b) >>> shamt;
      ALU_LUI:  alu_result = {imm, {(DATA_W-16){1'b0}}};
      default:  alu_result = sum;
    endcase
  end

  assign ovf = (ctrl.alu_op == ALU_SUB)
             ? ((op_a[DATA_W-1] != op_b[DATA_W-1]) && (diff[DATA_W-1] != op_a[DATA_W-1]))
             : ((op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum[DATA_W-1]  != op_a[DATA_W-1]));

`ifdef MIPS_CPU_OVF_TRAP_EN
  logic overflow_q, overflow_d;
  logic trap;

  assign trap       = ctrl.reg_write && ctrl.ovf_chk && ovf;
  assign wb_en      = ctrl.reg_write && !trap;
  assign overflow_d = overflow_q | trap;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) overflow_q <= 1'b0;
    else          overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`else
  logic unused_ovf;

  assign unused_ovf = ctrl.ovf_chk ^ ovf;
  assign wb_en      = ctrl.reg_write;
  assign overflow   = 1'b0;
`endif

  mips_regfile #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .AW(5)) regfile (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .we_i      (wb_en),
    .waddr_i   ((ctrl.dst_sel == DST_RD) ? rd : rt),
    .wdata_i   (alu_result),
    .raddr_a_i (rs),
    .rdata_a_o (rs_data),
    .raddr_b_i (rt),
    .rdata_b_o (rt_data),
    .raddr_d_i (dbg_raddr),
    .rdata_d_o (dbg_rdata)
  );

endmodule

// File: tb/tb_mips_cpu.sv
// Directed-vector bench for mips_cpu; expectations are hand-computed per
// instruction and follow MIPS_CPU_OVF_TRAP_EN when it is defined.
module tb_mips_cpu;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic [4:0]  dbg_raddr = 5'd0;
  logic [31:0] dbg_rdata, alu_result;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] snap [0:31];

  mips_cpu dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instruction (instruction),
    .dbg_raddr   (dbg_raddr),
    .dbg_rdata   (dbg_rdata),
    .alu_result  (alu_result),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Present a word after the falling edge, commit it on the rising edge.
  task automatic exec(input logic [31:0] w);
    @(negedge clock);
    instruction = w;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] rf(input int i);
    return dut.regfile.register_file[i];
  endfunction

  initial begin
    #2;
    for (int i = 0; i < 32; i++) chk($sformatf("reset_r%0d", i), rf(i), 32'h0);
    chk("reset_ovf", {31'h0, overflow}, 32'h0);
    #10 reset_n = 1'b1;

    @(negedge clock);
    instruction = 32'h20080006;
    #1 chk("alu_addi_comb", alu_result, 32'h6);
    @(posedge clock); #1;
    chk("addi_t0", rf(8), 32'h6);
    exec(32'h2009000B); chk("addi_t1", rf(9), 32'hB);
    exec(32'h01095020); chk("add_raw", rf(10), 32'h11);
    exec(32'h340BFFFF); chk("ori_zext", rf(11), 32'h0000FFFF);
    exec(32'h200CFFFF); chk("addi_sext", rf(12), 32'hFFFFFFFF);
    exec(32'h01287822); chk("sub", rf(15), 32'h5);
    exec(32'h0188802A); chk("slt", rf(16), 32'h1);
    exec(32'h0188882B); chk("sltu", rf(17), 32'h0);
    exec(32'h000C9103); chk("sra", rf(18), 32'hFFFFFFFF);
    exec(32'h000C9F02); chk("srl", rf(19), 32'hF);
    exec(32'h0009A100); chk("sll", rf(20), 32'hB0);
    exec(32'h0109A827); chk("nor", rf(21), 32'hFFFFFFF0);
    exec(32'h2D16FFFF); chk("sltiu", rf(22), 32'h1);
    exec(32'h397700FF); chk("xori", rf(23), 32'h0000FF00);

    dbg_raddr = 5'd10;
    #1 chk("dbg_r10", dbg_rdata, 32'h11);
    dbg_raddr = 5'd0;
    #1 chk("dbg_r0", dbg_rdata, 32'h0);

    for (int i = 0; i < 32; i++) snap[i] = rf(i);
    exec(32'h20000005);
    exec('x);
    exec(32'hFC000000);
    exec(32'h0109A83F);
    chk("r0_zero", rf(0), 32'h0);
    for (int i = 1; i < 32; i++) chk($sformatf("nop_r%0d", i), rf(i), snap[i]);

    exec(32'h3C0D7FFF); chk("lui", rf(13), 32'h7FFF0000);
    exec(32'h35ADFFFF); chk("ori_max", rf(13), 32'h7FFFFFFF);
    exec(32'h21AE0001);
`ifdef MIPS_CPU_OVF_TRAP_EN
    chk("ovf_trap_r14", rf(14), 32'h0);
    chk("ovf_flag", {31'h0, overflow}, 32'h1);
`else
    chk("ovf_wrap_r14", rf(14), 32'h80000000);
    chk("ovf_flag", {31'h0, overflow}, 32'h0);
`endif
    exec(32'h25AE0001); chk("addiu_nontrap", rf(14), 32'h80000000);
`ifdef MIPS_CPU_OVF_TRAP_EN
    chk("ovf_sticky", {31'h0, overflow}, 32'h1);
`else
    chk("ovf_sticky", {31'h0, overflow}, 32'h0);
`endif

    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    for (int i = 0; i < 32; i++) chk($sformatf("midrst_r%0d", i), rf(i), 32'h0);
    chk("midrst_ovf", {31'h0, overflow}, 32'h0);
    #10 reset_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_cpu.md
Name: mips_cpu

Overview:
Single-cycle MIPS32 integer execution core without fetch. It is driven directly by a 32-bit instruction word and has no PC or data memory. Each rising clock edge it decodes the presented instruction, reads the register file, runs the ALU and writes back. It serves as the datapath block that a later fetch/memory stage wraps around.

Parameters:
- NUM_REGS, 32, number of architectural registers; fixed at 32 (5-bit specifiers).
- DATA_W, 32, register and ALU width.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- instruction  input  32  instruction executed at the next rising edge.
- dbg_raddr  input  5  debug register read address.
- dbg_rdata  output  32  combinational read of register dbg_raddr; $0 always reads 0.
- alu_result  output  32  combinational ALU result for the current instruction.
- overflow  output  1  sticky signed-overflow flag; tied 0 without the optional feature.

Behaviour:
- Reset: while reset_n=0, all 32 registers clear to 0 and overflow clears to 0, asynchronously.
- Register file is instance `regfile` holding array `register_file[0:31]` of 32-bit entries. The bench accesses it hierarchically, so both names are mandatory.
- Reads: 2 combinational read ports (rs, rt) plus the debug port. Register 0 reads 0. Writes to register 0 are discarded.
- Latency: the write takes effect at the first rising edge after the instruction is stable and is visible immediately after that edge. Each instruction completes in 1 cycle and the core has no internal pipeline state.
- Decode (opcode = instr[31:26]):
  - R-type (opcode 0x00), dest rd. Funct values: 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x2A slt (signed), 0x2B sltu.
  - R-type shifts use shamt = instr[10:6] applied to rt: 0x00 sll, 0x02 srl, 0x03 sra.
  - I-type, dest rt, imm = instr[15:0]:
    - 0x08 addi, 0x09 addiu, 0x0A slti, 0x0B sltiu: imm sign-extended. sltiu compares unsigned after sign extension.
    - 0x0C andi, 0x0D ori, 0x0E xori: imm zero-extended.
    - 0x0F lui: result = imm<<16.
- Arithmetic wraps modulo 2^32. slt/slti/sltu/sltiu produce 0 or 1.
- Unsupported opcode or funct, or any X/Z bits in instruction: no register write, no flag change (treated as NOP). alu_result for these cases is don't-care.
- Consecutive instructions with read-after-write dependencies work naturally: each cycle reads the values committed at the previous edge.

Optional Feature:
- Macro MIPS_CPU_OVF_TRAP_EN.
- Defined: signed overflow on add, sub or addi suppresses the register write and sets overflow to 1. The flag stays 1 until reset. addu, subu and addiu are never trapped.
- Undefined: add, sub and addi wrap and write like their unsigned forms; overflow is constant 0.

Decomposition:
- Package mips_pkg:
  - opcode and funct localparams;
  - ALU operation enum (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, LUI);
  - a decoded-control struct (reg_write, dst_sel, imm_ext_sel, alu_src_imm, alu_op, ovf_chk).
- Sub-module mips_regfile, instantiated as `regfile`: 2R+1W, async reset, $0 hardwired.
- Decode and ALU stay in mips_cpu.

Test Plan:
- Reset: pulse reset_n low mid-cycle -> all register_file entries = 0 immediately, overflow = 0.
- addi $t0,$zero,6 (0x20080006) then addi $t1,$zero,11 (0x2009000B) -> register_file[8] = 0x6, then register_file[9] = 0xB.
- add $t2,$t0,$t1 (0x01095020) directly after the above -> register_file[10] = 0x11.
- Immediate extension:
  - ori $t3,$zero,0xFFFF (0x340BFFFF) -> register_file[11] = 0x0000FFFF;
  - addi $t4,$zero,-1 (0x200CFFFF) -> register_file[12] = 0xFFFFFFFF.
- addi $zero,$zero,5 (0x20000005), then instruction = X, then opcode 0x3F -> register_file[0] = 0, no other register changes.
- Overflow:
  - sequence: lui $t5,0x7FFF (0x3C0D7FFF); ori $t5,$t5,0xFFFF (0x35ADFFFF); addi $t6,$t5,1 (0x21AE0001).
  - With MIPS_CPU_OVF_TRAP_EN: register_file[14] unchanged, overflow = 1.
  - Without: register_file[14] = 0x80000000, overflow = 0.
